// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the single-transfer Wishbone initiator.
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned CNT_W              = 8;
  localparam int unsigned ERR_W              = 8;

endpackage : wb_initiator_pkg

// File: rtl/wb_initiator_timeout_ctr.sv
// Per-transfer wait counter with a saturating count of transfers that timed out.
module wb_timeout_ctr
  import wb_initiator_pkg::*;
(
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             clear,
  input  logic             enable,
  input  logic             ack,
  input  logic [CNT_W-1:0] limit,
  output logic             expired,
  output logic [ERR_W-1:0] err_count
);

  logic [CNT_W-1:0] count_q;

  // Expiry marks the last allowed wait cycle; an ACK in that cycle still wins.
  assign expired = enable && (count_q == (limit - CNT_W'(1)));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count_q   <= '0;
      err_count <= '0;
    end else begin
      if (clear) begin
        count_q <= '0;
      end else if (enable) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (expired && !ack && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule : wb_timeout_ctr

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one command in, one bus cycle, one response out.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned ADR_W          = 32,
  parameter int unsigned DAT_W          = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  output logic [ERR_W-1:0]   err_count
);

  localparam int unsigned SEL_W = DAT_W / 8;

  state_e           state_q, state_d;
  logic             cmd_ready_d;
  logic             rsp_valid_d;
  logic [DAT_W-1:0] rsp_dat_d;
  logic             rsp_err_d;
  logic             cyc_d;
  logic             load_cmd;
  logic             ctr_clear;
  logic             ctr_enable;
  logic             expired;

  assign ctr_enable = (state_q == ST_BUS);

  wb_timeout_ctr u_timeout_ctr (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clear     (ctr_clear),
    .enable    (ctr_enable),
    .ack       (wbm_ack_i),
    .limit     (CNT_W'(TIMEOUT_CYCLES)),
    .expired   (expired),
    .err_count (err_count)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
    rsp_err_d   = rsp_err;
    cyc_d       = wbm_cyc_o;
    load_cmd    = 1'b0;
    ctr_clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          load_cmd    = 1'b1;
          ctr_clear   = 1'b1;
          cyc_d       = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = wbm_we_o ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else if (expired) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_dat   <= rsp_dat_d;
      rsp_err   <= rsp_err_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= cyc_d;
      // Payload is held between transfers; only CYC/STB qualify the bus.
      if (load_cmd) begin
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= SEL_W'(cmd_sel);
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
      end
    end
  end

endmodule : wb_initiator
